// File: rtl/demux18_stream.sv
// One-entry stream register that routes each accepted word to one of eight
// valid/ready output channels and keeps a transfer counter per channel.
module demux18_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
    input  logic             cnt_clr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] data_reg;
    logic [2:0]       sel_reg;
    logic             accept_en;
    logic             release_en;
    logic [CNT_W-1:0] cnt_all [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Only out_ready of the held channel matters; in_ready never depends on in_valid.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        release_en = 1'b0;
        accept_en  = 1'b0;
        case (state_reg)
            EMPTY: begin
                in_ready = rst_n;
            end
            FULL: begin
                release_en = out_ready[sel_reg];
                in_ready   = rst_n & out_ready[sel_reg];
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        accept_en = in_valid & in_ready;
        if (accept_en) begin
            state_next = FULL;
        end else if (release_en) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            sel_reg  <= '0;
        end else if (accept_en) begin
            data_reg <= in_data;
            sel_reg  <= in_sel;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = (state_reg == FULL) ? (8'b1 << sel_reg) : 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Clear takes priority over a release on the same edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (release_en && (sel_reg == 3'(gi))) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign cnt_out = cnt_all[cnt_sel];

endmodule

// File: doc/demux18_stream.md
DEMUX18_STREAM -- requirements
Module: demux18_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width of every channel.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of each per-channel transfer counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts word this cycle.
REQ-007 in_data  input  WIDTH  upstream word.
REQ-008 in_sel  input  3  destination channel 0..7, sampled with in_data.
REQ-009 out_data  output  WIDTH  held word, shared by all channels.
REQ-010 out_valid  output  8  one-hot valid, bit k = channel k.
REQ-011 out_ready  input  8  per-channel ready, bit k = channel k.
REQ-012 cnt_sel  input  3  channel whose counter is read.
REQ-013 cnt_out  output  CNT_W  transfer count of channel cnt_sel.
REQ-014 cnt_clr  input  1  synchronous clear of all counters.

Function
REQ-015 SHALL hold one entry (data reg, 3-bit sel reg) in a two-state FSM: EMPTY, FULL.
REQ-016 Input handshake: word accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 Output handshake: channel k releases on a rising edge where out_valid[k]=1 and out_ready[k]=1.
REQ-018 in_ready SHALL be combinational: 1 in EMPTY; in FULL equal to out_ready[held_sel]; 0 while rst_n=0.
REQ-019 out_valid SHALL be all-zero in EMPTY; in FULL exactly bit held_sel set; never more than one bit.
REQ-020 out_data SHALL equal the held word in FULL and keep its last value in EMPTY.
REQ-021 EMPTY + accept -> FULL, load in_data/in_sel; out_valid rises the next cycle (latency 1).
REQ-022 FULL + release, no accept -> EMPTY.
REQ-023 FULL + release + accept same edge -> stay FULL, load new word; sustained throughput 1 word/cycle.
REQ-024 FULL without release SHALL hold data and sel stable; in_valid ignored (in_ready=0).
REQ-025 out_ready bits of non-selected channels SHALL be ignored.
REQ-026 No combinational path from in_valid/in_data/in_sel to any output.
REQ-027 Counter k SHALL increment by 1 on each release on channel k, wrapping 2^CNT_W-1 -> 0.
REQ-028 cnt_clr=1 SHALL zero all counters at the edge; clear wins over a coincident increment.
REQ-029 cnt_out SHALL be combinational, equal to counter[cnt_sel].

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM EMPTY, out_valid=8'h00, out_data=0, held sel=0, all counters 0, in_ready=0.
REQ-031 Reset asserted while FULL SHALL discard the held word with no release and no counter increment.
REQ-032 First accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 Basic route: reset, in_data=8'hA5, in_sel=3, 1-cycle in_valid, out_ready=8'hFF -> next cycle out_valid=8'h08, out_data=8'hA5; then EMPTY; cnt_sel=3 gives cnt_out=1.
REQ-034 Backpressure: hold word for ch5, out_ready=8'hDF for 4 cycles -> out_valid=8'h20 stable, data stable, in_ready=0; ch5 ready=1 -> release, count5=1.
REQ-035 Streaming: 8 back-to-back words, sel 0..7, data 8'h10..8'h17, out_ready=8'hFF -> in_ready stays 1, one word out per cycle in order, every counter =1.
REQ-036 Wrap/clear: 256 releases on ch0 -> count0=0; 3 more -> 3; cnt_clr coincident with a release -> 0.
REQ-037 Reset mid-op: FULL for ch6 with out_ready=0, pulse rst_n low between edges -> out_valid=0 at once, count6 unchanged at 0, in_ready=0 during reset.
REQ-038 Random: constrained-random in_valid/in_sel/out_ready vs scoreboard -> no loss, duplication or reorder; counters match per-channel release totals.
